gmii_mac_tx: RTL

GMII_MAC_TX -- requirements
Module: gmii_mac_tx

---
 rtl/eth_pkg.sv | 37 +++
 rtl/eth_crc32_d8.sv | 31 +++
 rtl/gmii_mac_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet transmit path.
//   PREAMBLE_BYTE / SFD_BYTE : GMII frame-start symbols
//   PREAMBLE_LEN             : number of 0x55 bytes before the SFD
//   CRC_POLY                 : CRC-32 generator, normal (MSB-first) form
//   CRC_INIT                 : CRC register value at the start of a frame
//   CRC_RESIDUE              : register value after data plus a correct FCS
//   tx_state_e               : transmit FSM states
//   reflect32()              : bit reversal, turns CRC_POLY into its LSB-first form
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          PREAMBLE_LEN  = 7;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SFD      = 3'd2,
      ST_DATA     = 3'd3,
      ST_PAD      = 3'd4,
      ST_FCS      = 3'd5,
      ST_DROP     = 3'd6,
      ST_IFG      = 3'd7
   } tx_state_e;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte-per-cycle CRC-32 update, purely combinational.
// The register is kept in reflected form: bit 0 of each data byte is
// processed first, matching the order bits leave on the Ethernet wire.
//   crc_in   : current CRC register
//   data_in  : byte to absorb
//   crc_out  : CRC register after absorbing data_in
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

   logic [31:0] crc_work;

   always_comb begin
      crc_work = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0] ^ data_in[i]) begin
            crc_work = (crc_work >> 1) ^ POLY_REFL;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit MAC: frames a byte stream with preamble/SFD, pads short
// payloads, appends the CRC-32 FCS and enforces the inter-frame gap.
//   gmii_tx_clk : sole clock, rising edge
//   reset       : synchronous, active-high
//   s_data/s_valid/s_last/s_ready : payload stream, destination MAC first
//   gmii_txd/gmii_tx_en/gmii_tx_er : registered GMII transmit outputs
//   busy        : high whenever the FSM is outside IDLE
// An underrun (s_valid low in DATA before s_last) emits one error symbol,
// then the rest of the frame is swallowed up to s_last.
module gmii_mac_tx
   import eth_pkg::*;
#(
   parameter int IFG_CYCLES  = 12,
   parameter int MIN_PAYLOAD = 60
) (
   input  logic       gmii_tx_clk,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy
);

   localparam logic [15:0] MIN_PAY_W = 16'(MIN_PAYLOAD);
   localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);
   localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] FCS_LAST  = 16'd3;

   tx_state_e   state_q, state_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;   // payload + pad bytes, saturating
   logic [15:0] phase_q, phase_d;         // position inside PREAMBLE / FCS / IFG
   logic [31:0] crc_q, crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;

   logic [31:0] crc_next;
   logic [7:0]  crc_byte;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;
   logic [15:0] byte_inc;

   // Pad bytes are zero, so the CRC input is the stream byte only in DATA.
   assign crc_byte = (state_q == ST_DATA) ? s_data : 8'h00;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data_in (crc_byte),
      .crc_out (crc_next)
   );

   assign fcs_word = ~crc_q;
   assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

   // FCS goes out least-significant byte first.
   always_comb begin
      fcs_byte = fcs_word[7:0];
      case (phase_q[1:0])
         2'd0: fcs_byte = fcs_word[7:0];
         2'd1: fcs_byte = fcs_word[15:8];
         2'd2: fcs_byte = fcs_word[23:16];
         2'd3: fcs_byte = fcs_word[31:24];
         default: fcs_byte = fcs_word[7:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      phase_d    = phase_q;
      crc_d      = crc_q;
      txd_d      = 8'h00;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               // The first preamble byte is issued on the way out of IDLE so
               // that back-to-back frames are separated by exactly the IFG.
               state_d    = ST_PREAMBLE;
               phase_d    = 16'd1;
               byte_cnt_d = 16'd0;
               crc_d      = CRC_INIT;
               txd_d      = PREAMBLE_BYTE;
               tx_en_d    = 1'b1;
            end
         end

         ST_PREAMBLE: begin
            txd_d   = PREAMBLE_BYTE;
            tx_en_d = 1'b1;
            phase_d = phase_q + 16'd1;
            if (phase_q == PRE_LAST) begin
               state_d = ST_SFD;
            end
         end

         ST_SFD: begin
            txd_d   = SFD_BYTE;
            tx_en_d = 1'b1;
            state_d = ST_DATA;
         end

         ST_DATA: begin
            if (s_valid) begin
               txd_d      = s_data;
               tx_en_d    = 1'b1;
               crc_d      = crc_next;
               byte_cnt_d = byte_inc;
               if (s_last) begin
                  phase_d = 16'd0;
                  state_d = (byte_inc < MIN_PAY_W) ? ST_PAD : ST_FCS;
               end
            end else begin
               // Underrun: one error symbol, then the frame is abandoned.
               txd_d   = 8'h00;
               tx_en_d = 1'b1;
               tx_er_d = 1'b1;
               state_d = ST_DROP;
            end
         end

         ST_PAD: begin
            txd_d      = 8'h00;
            tx_en_d    = 1'b1;
            crc_d      = crc_next;
            byte_cnt_d = byte_inc;
            if (byte_inc >= MIN_PAY_W) begin
               phase_d = 16'd0;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            txd_d   = fcs_byte;
            tx_en_d = 1'b1;
            phase_d = phase_q + 16'd1;
            if (phase_q == FCS_LAST) begin
               phase_d = 16'd0;
               state_d = ST_IFG;
            end
         end

         ST_DROP: begin
            if (s_valid && s_last) begin
               phase_d = 16'd0;
               state_d = ST_IFG;
            end
         end

         ST_IFG: begin
            phase_d = phase_q + 16'd1;
            if (phase_q == IFG_LAST) begin
               phase_d = 16'd0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 16'd0;
         phase_q    <= 16'd0;
         crc_q      <= CRC_INIT;
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         phase_q    <= phase_d;
         crc_q      <= crc_d;
         txd_q      <= txd_d;
         tx_en_q    <= tx_en_d;
         tx_er_q    <= tx_er_d;
      end
   end

   assign s_ready    = (state_q == ST_DATA) || (state_q == ST_DROP);
   assign busy       = (state_q != ST_IDLE);
   assign gmii_txd   = txd_q;
   assign gmii_tx_en = tx_en_q;
   assign gmii_tx_er = tx_er_q;

endmodule
